// File: rtl/sdram_chip_responder.sv
// sdram_chip_responder
//   Chip-side model of a 16-bit SDR SDRAM for controller benches and FPGA
//   loopback builds. Decodes commands, tracks per-bank row state, keeps a
//   small backing array and returns read data at the programmed CAS latency.
//   Any command that raises an error flag is otherwise ignored.
// Ports:
//   clk, init_n          clock (rising edge), async active-low reset
//   sd_ncs/nras/ncas/nwe command pins
//   sd_a, sd_ba          multiplexed address, bank select
//   sd_dqml, sd_dqmh     byte masks (write: same edge, read: latency 2)
//   sd_dq_in             write data from controller
//   sd_dq_out, sd_dq_oe  read data and per-byte output enable (bit1 = high)
//   mode_loaded, cas_lat mode register status
//   err, err_clr         sticky violation flags and their synchronous clear
module sdram_chip_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned TRCD      = 3,
    parameter int unsigned TRP       = 3,
    parameter int unsigned TRFC      = 8
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [12:0] sd_a,
    input  logic [1:0]  sd_ba,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic [1:0]  sd_dq_oe,
    output logic        mode_loaded,
    output logic [1:0]  cas_lat,
    output logic [5:0]  err,
    input  logic        err_clr
);

    localparam int unsigned CW = 8;

    typedef enum logic [3:0] {
        CMD_INHIBIT, CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE,
        CMD_BURST_TERM, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE
    } cmd_t;

    typedef enum logic [1:0] {
        BANK_IDLE, BANK_ACTIVE, BANK_PRECHARGING
    } bank_state_t;

    cmd_t          cmd;
    bank_state_t   bank_st    [4];
    bank_state_t   bank_st_nx [4];
    logic [12:0]   bank_row    [4];
    logic [12:0]   bank_row_nx [4];
    logic [CW-1:0] bank_cnt    [4];
    logic [CW-1:0] bank_cnt_nx [4];
    logic [CW-1:0] ref_cnt;
    logic [CW-1:0] ref_cnt_nx;
    logic          mode_loaded_nx;
    logic [1:0]    cas_lat_nx;
    logic [5:0]    err_new;
    logic          do_read;
    logic          do_write;
    logic          all_idle;
    logic          busy;
    logic [23:0]   full_addr;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]   mem [0:(1<<ADDR_BITS)-1];
    logic [1:0]    rd_v;
    logic [15:0]   rd_d [2];
    logic [1:0]    dqm_q;
    logic [1:0]    oe_q;
    logic          out_v;
    logic [15:0]   out_d;

    always_comb begin
        cmd = CMD_NOP;
        casez ({sd_ncs, sd_nras, sd_ncas, sd_nwe})
            4'b1???: cmd = CMD_INHIBIT;
            4'b0111: cmd = CMD_NOP;
            4'b0011: cmd = CMD_ACTIVE;
            4'b0101: cmd = CMD_READ;
            4'b0100: cmd = CMD_WRITE;
            4'b0110: cmd = CMD_BURST_TERM;
            4'b0010: cmd = CMD_PRECHARGE;
            4'b0001: cmd = CMD_REFRESH;
            default: cmd = CMD_LOAD_MODE;
        endcase
    end

    always_comb begin
        all_idle = 1'b1;
        for (int unsigned b = 0; b < 4; b++)
            if (bank_st[b] != BANK_IDLE) all_idle = 1'b0;
    end

    assign busy      = (ref_cnt != '0);
    assign full_addr = {sd_ba, bank_row[sd_ba], sd_a[8:0]};
    assign idx       = ADDR_BITS'(full_addr);

    always_comb begin
        bank_st_nx     = bank_st;
        bank_row_nx    = bank_row;
        bank_cnt_nx    = bank_cnt;
        ref_cnt_nx     = busy ? ref_cnt - 1'b1 : '0;
        mode_loaded_nx = mode_loaded;
        cas_lat_nx     = cas_lat;
        err_new        = '0;
        do_read        = 1'b0;
        do_write       = 1'b0;

        // Timers advance first; command decode below sees only current state,
        // so a bank finishing precharge this edge is still busy for this command.
        for (int unsigned b = 0; b < 4; b++) begin
            case (bank_st[b])
                BANK_ACTIVE:
                    if (bank_cnt[b] != '0) bank_cnt_nx[b] = bank_cnt[b] - 1'b1;
                BANK_PRECHARGING:
                    if (bank_cnt[b] <= CW'(1)) begin
                        bank_st_nx[b]  = BANK_IDLE;
                        bank_cnt_nx[b] = '0;
                    end else begin
                        bank_cnt_nx[b] = bank_cnt[b] - 1'b1;
                    end
                default: ;
            endcase
        end

        case (cmd)
            CMD_ACTIVE: begin
                err_new[0] = (bank_st[sd_ba] != BANK_IDLE);
                err_new[3] = busy;
                err_new[4] = ~mode_loaded;
                if (err_new == '0) begin
                    bank_st_nx[sd_ba]  = BANK_ACTIVE;
                    bank_row_nx[sd_ba] = sd_a;
                    bank_cnt_nx[sd_ba] = CW'(TRCD - 1);
                end
            end
            CMD_READ, CMD_WRITE: begin
                err_new[1] = (bank_st[sd_ba] != BANK_ACTIVE);
                err_new[2] = (bank_st[sd_ba] == BANK_ACTIVE) && (bank_cnt[sd_ba] != '0);
                err_new[3] = busy;
                err_new[4] = ~mode_loaded;
                if (err_new == '0) begin
                    do_read  = (cmd == CMD_READ);
                    do_write = (cmd == CMD_WRITE);
                    if (sd_a[10]) begin
                        bank_st_nx[sd_ba]  = BANK_PRECHARGING;
                        bank_cnt_nx[sd_ba] = CW'(TRP - 1);
                    end
                end
            end
            CMD_PRECHARGE: begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if ((sd_a[10] || (2'(b) == sd_ba)) && bank_st[b] == BANK_ACTIVE) begin
                        bank_st_nx[b]  = BANK_PRECHARGING;
                        bank_cnt_nx[b] = CW'(TRP - 1);
                    end
                end
            end
            CMD_REFRESH: begin
                err_new[3] = busy;
                err_new[4] = ~mode_loaded;
                if (err_new == '0) ref_cnt_nx = CW'(TRFC - 1);
            end
            CMD_LOAD_MODE: begin
                if (!all_idle || busy) begin
                    err_new[3] = 1'b1;
                end else if ((sd_a[6:4] == 3'd2 || sd_a[6:4] == 3'd3) && sd_a[2:0] == 3'd0) begin
                    mode_loaded_nx = 1'b1;
                    cas_lat_nx     = sd_a[5:4];
                end else begin
                    err_new[5] = 1'b1;
                end
            end
            CMD_BURST_TERM: err_new[5] = 1'b1;
            default: ;
        endcase
    end

    // Backing store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (!sd_dqml) mem[idx][7:0]  <= sd_dq_in[7:0];
            if (!sd_dqmh) mem[idx][15:8] <= sd_dq_in[15:8];
        end
    end

    // The output register is loaded one edge before the controller samples,
    // so it draws from stage CL-2 and uses the DQM captured on the prior edge.
    assign out_v = (cas_lat == 2'd2) ? rd_v[0] : rd_v[1];
    assign out_d = (cas_lat == 2'd2) ? rd_d[0] : rd_d[1];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int unsigned b = 0; b < 4; b++) begin
                bank_st[b]  <= BANK_IDLE;
                bank_row[b] <= '0;
                bank_cnt[b] <= '0;
            end
            ref_cnt     <= '0;
            mode_loaded <= 1'b0;
            cas_lat     <= 2'd3;
            err         <= '0;
            rd_v        <= '0;
            rd_d[0]     <= '0;
            rd_d[1]     <= '0;
            dqm_q       <= '0;
            oe_q        <= '0;
            sd_dq_out   <= '0;
        end else begin
            bank_st     <= bank_st_nx;
            bank_row    <= bank_row_nx;
            bank_cnt    <= bank_cnt_nx;
            ref_cnt     <= ref_cnt_nx;
            mode_loaded <= mode_loaded_nx;
            cas_lat     <= cas_lat_nx;
            err         <= (err_clr ? '0 : err) | err_new;
            rd_v        <= {rd_v[0], do_read};
            rd_d[0]     <= mem[idx];
            rd_d[1]     <= rd_d[0];
            dqm_q       <= {sd_dqmh, sd_dqml};
            sd_dq_out   <= out_v ? out_d : '0;
            oe_q        <= out_v ? ~dqm_q : 2'b00;
        end
    end

    // A WRITE on the bus owns DQ that cycle; any pending read output is dropped.
    assign sd_dq_oe = (cmd == CMD_WRITE) ? 2'b00 : oe_q;

endmodule
